// File: rtl/id_ex_stage.sv
`default_nettype none
// ============================================================================
//  Module   : id_ex_stage
//  Brief    : ID/EX pipeline register with load-use hazard detection, one-
//             bubble insertion, EX flush, downstream freeze and a saturating
//             load-use bubble counter.
//  Revision : 1.0 - initial release
// ============================================================================
module id_ex_stage #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             id_valid,
    input  logic             id_RegWrite,
    input  logic             id_MemRead,
    input  logic             id_MemWrite,
    input  logic             id_MemtoReg,
    input  logic             id_ALUSrc,
    input  logic             id_Branch,
    input  logic             id_Jump,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic [4:0]       id_rd,
    input  logic [XLEN-1:0]  id_pc,
    input  logic [XLEN-1:0]  id_rs1_data,
    input  logic [XLEN-1:0]  id_rs2_data,
    input  logic [XLEN-1:0]  id_imm,
    input  logic [2:0]       id_funct3,
    input  logic [3:0]       id_alu_op,

    input  logic             flush_ex,
    input  logic             mem_stall,

    output logic             ex_valid,
    output logic             RegWrite_ex,
    output logic             MemRead_ex,
    output logic             MemWrite_ex,
    output logic             MemtoReg_ex,
    output logic             ALUSrc_ex,
    output logic             Branch_ex,
    output logic             Jump_ex,
    output logic [4:0]       rs1_ex,
    output logic [4:0]       rs2_ex,
    output logic [4:0]       rd_ex,
    output logic [XLEN-1:0]  ex_pc,
    output logic [XLEN-1:0]  rs1_data_ex,
    output logic [XLEN-1:0]  rs2_data_ex,
    output logic [XLEN-1:0]  imm_ex,
    output logic [2:0]       funct3_ex,
    output logic [3:0]       alu_op_ex,

    output logic             stall_if_id,
    output logic [CNT_W-1:0] bubble_count
);

    localparam logic [CNT_W-1:0] c_cnt_max = '1;

    // EX pipeline register state
    logic             ex_valid_q,    ex_valid_d;
    logic             reg_write_q,   reg_write_d;
    logic             mem_read_q,    mem_read_d;
    logic             mem_write_q,   mem_write_d;
    logic             mem_to_reg_q,  mem_to_reg_d;
    logic             alu_src_q,     alu_src_d;
    logic             branch_q,      branch_d;
    logic             jump_q,        jump_d;
    logic [4:0]       rs1_q,         rs1_d;
    logic [4:0]       rs2_q,         rs2_d;
    logic [4:0]       rd_q,          rd_d;
    logic [XLEN-1:0]  pc_q,          pc_d;
    logic [XLEN-1:0]  rs1_data_q,    rs1_data_d;
    logic [XLEN-1:0]  rs2_data_q,    rs2_data_d;
    logic [XLEN-1:0]  imm_q,         imm_d;
    logic [2:0]       funct3_q,      funct3_d;
    logic [3:0]       alu_op_q,      alu_op_d;
    logic [CNT_W-1:0] bubble_cnt_q,  bubble_cnt_d;

    logic             load_use;
    logic             load_bubble;

    // Hazard: the load in EX writes a non-zero register the ID instruction reads
    always_comb begin
        load_use = id_valid & ex_valid_q & mem_read_q & (rd_q != 5'd0) &
                   ((rd_q == id_rs1) | (rd_q == id_rs2));
    end

    // Front-end hold: freeze always wins; a flush cancels the load-use hold
    always_comb begin
        stall_if_id = mem_stall | (load_use & ~flush_ex);
    end

    // Next EX contents by priority: freeze, flush, load-use, normal load
    always_comb begin
        ex_valid_d   = ex_valid_q;
        reg_write_d  = reg_write_q;
        mem_read_d   = mem_read_q;
        mem_write_d  = mem_write_q;
        mem_to_reg_d = mem_to_reg_q;
        alu_src_d    = alu_src_q;
        branch_d     = branch_q;
        jump_d       = jump_q;
        rs1_d        = rs1_q;
        rs2_d        = rs2_q;
        rd_d         = rd_q;
        pc_d         = pc_q;
        rs1_data_d   = rs1_data_q;
        rs2_data_d   = rs2_data_q;
        imm_d        = imm_q;
        funct3_d     = funct3_q;
        alu_op_d     = alu_op_q;
        bubble_cnt_d = bubble_cnt_q;
        load_bubble  = 1'b0;

        if (!mem_stall) begin
            load_bubble = flush_ex | load_use | ~id_valid;
            if (load_bubble) begin
                ex_valid_d   = 1'b0;
                reg_write_d  = 1'b0;
                mem_read_d   = 1'b0;
                mem_write_d  = 1'b0;
                mem_to_reg_d = 1'b0;
                alu_src_d    = 1'b0;
                branch_d     = 1'b0;
                jump_d       = 1'b0;
                rs1_d        = 5'd0;
                rs2_d        = 5'd0;
                rd_d         = 5'd0;
                pc_d         = '0;
                rs1_data_d   = '0;
                rs2_data_d   = '0;
                imm_d        = '0;
                funct3_d     = 3'd0;
                alu_op_d     = 4'd0;
            end else begin
                ex_valid_d   = 1'b1;
                reg_write_d  = id_RegWrite;
                mem_read_d   = id_MemRead;
                mem_write_d  = id_MemWrite;
                mem_to_reg_d = id_MemtoReg;
                alu_src_d    = id_ALUSrc;
                branch_d     = id_Branch;
                jump_d       = id_Jump;
                rs1_d        = id_rs1;
                rs2_d        = id_rs2;
                rd_d         = id_rd;
                pc_d         = id_pc;
                rs1_data_d   = id_rs1_data;
                rs2_data_d   = id_rs2_data;
                imm_d        = id_imm;
                funct3_d     = id_funct3;
                alu_op_d     = id_alu_op;
            end
            // Only hazard bubbles are counted; flushes take precedence
            if (!flush_ex && load_use && (bubble_cnt_q != c_cnt_max)) begin
                bubble_cnt_d = bubble_cnt_q + 1'b1;
            end
        end
    end

    // EX register and bubble counter, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid_q   <= 1'b0;
            reg_write_q  <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_to_reg_q <= 1'b0;
            alu_src_q    <= 1'b0;
            branch_q     <= 1'b0;
            jump_q       <= 1'b0;
            rs1_q        <= 5'd0;
            rs2_q        <= 5'd0;
            rd_q         <= 5'd0;
            pc_q         <= '0;
            rs1_data_q   <= '0;
            rs2_data_q   <= '0;
            imm_q        <= '0;
            funct3_q     <= 3'd0;
            alu_op_q     <= 4'd0;
            bubble_cnt_q <= '0;
        end else begin
            ex_valid_q   <= ex_valid_d;
            reg_write_q  <= reg_write_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            mem_to_reg_q <= mem_to_reg_d;
            alu_src_q    <= alu_src_d;
            branch_q     <= branch_d;
            jump_q       <= jump_d;
            rs1_q        <= rs1_d;
            rs2_q        <= rs2_d;
            rd_q         <= rd_d;
            pc_q         <= pc_d;
            rs1_data_q   <= rs1_data_d;
            rs2_data_q   <= rs2_data_d;
            imm_q        <= imm_d;
            funct3_q     <= funct3_d;
            alu_op_q     <= alu_op_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    // Registered outputs
    always_comb begin
        ex_valid     = ex_valid_q;
        RegWrite_ex  = reg_write_q;
        MemRead_ex   = mem_read_q;
        MemWrite_ex  = mem_write_q;
        MemtoReg_ex  = mem_to_reg_q;
        ALUSrc_ex    = alu_src_q;
        Branch_ex    = branch_q;
        Jump_ex      = jump_q;
        rs1_ex       = rs1_q;
        rs2_ex       = rs2_q;
        rd_ex        = rd_q;
        ex_pc        = pc_q;
        rs1_data_ex  = rs1_data_q;
        rs2_data_ex  = rs2_data_q;
        imm_ex       = imm_q;
        funct3_ex    = funct3_q;
        alu_op_ex    = alu_op_q;
        bubble_count = bubble_cnt_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_id_ex_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_id_ex_stage
//  Brief    : Scoreboard testbench for id_ex_stage: random and directed
//             stimulus checked against a rule-level reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_id_ex_stage;

    localparam int XLEN  = 32;
    localparam int CNT_W = 4;
    localparam int CMAX  = (1 << CNT_W) - 1;

    // Architectural view of the EX register; packed in DUT output order
    typedef struct packed {
        logic        valid;
        logic [6:0]  ctrl;   // RegWrite MemRead MemWrite MemtoReg ALUSrc Branch Jump
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] pc;
        logic [31:0] d1;
        logic [31:0] d2;
        logic [31:0] imm;
        logic [2:0]  f3;
        logic [3:0]  op;
    } ex_t;

    typedef struct packed {
        ex_t  id;      // valid = id_valid
        logic flush;
        logic mstall;
    } stim_t;

    typedef struct packed {
        logic stall;
        ex_t  ex;
        int   cnt;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             id_valid = 0, id_RegWrite = 0, id_MemRead = 0, id_MemWrite = 0;
    logic             id_MemtoReg = 0, id_ALUSrc = 0, id_Branch = 0, id_Jump = 0;
    logic [4:0]       id_rs1 = 0, id_rs2 = 0, id_rd = 0;
    logic [XLEN-1:0]  id_pc = 0, id_rs1_data = 0, id_rs2_data = 0, id_imm = 0;
    logic [2:0]       id_funct3 = 0;
    logic [3:0]       id_alu_op = 0;
    logic             flush_ex = 0, mem_stall = 0;
    logic             ex_valid, RegWrite_ex, MemRead_ex, MemWrite_ex, MemtoReg_ex;
    logic             ALUSrc_ex, Branch_ex, Jump_ex;
    logic [4:0]       rs1_ex, rs2_ex, rd_ex;
    logic [XLEN-1:0]  ex_pc, rs1_data_ex, rs2_data_ex, imm_ex;
    logic [2:0]       funct3_ex;
    logic [3:0]       alu_op_ex;
    logic             stall_if_id;
    logic [CNT_W-1:0] bubble_count;

    id_ex_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_valid(id_valid), .id_RegWrite(id_RegWrite), .id_MemRead(id_MemRead),
        .id_MemWrite(id_MemWrite), .id_MemtoReg(id_MemtoReg), .id_ALUSrc(id_ALUSrc),
        .id_Branch(id_Branch), .id_Jump(id_Jump),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_pc(id_pc), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_funct3(id_funct3), .id_alu_op(id_alu_op),
        .flush_ex(flush_ex), .mem_stall(mem_stall),
        .ex_valid(ex_valid), .RegWrite_ex(RegWrite_ex), .MemRead_ex(MemRead_ex),
        .MemWrite_ex(MemWrite_ex), .MemtoReg_ex(MemtoReg_ex), .ALUSrc_ex(ALUSrc_ex),
        .Branch_ex(Branch_ex), .Jump_ex(Jump_ex),
        .rs1_ex(rs1_ex), .rs2_ex(rs2_ex), .rd_ex(rd_ex),
        .ex_pc(ex_pc), .rs1_data_ex(rs1_data_ex), .rs2_data_ex(rs2_data_ex), .imm_ex(imm_ex),
        .funct3_ex(funct3_ex), .alu_op_ex(alu_op_ex),
        .stall_if_id(stall_if_id), .bubble_count(bubble_count)
    );

    always #5 clk = ~clk;

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t sb_q[$];
    ex_t  m_ex;     // model of what EX currently holds
    int   m_cnt;    // model bubble count

    function automatic ex_t dut_ex();
        return {ex_valid, RegWrite_ex, MemRead_ex, MemWrite_ex, MemtoReg_ex, ALUSrc_ex,
                Branch_ex, Jump_ex, rs1_ex, rs2_ex, rd_ex, ex_pc, rs1_data_ex,
                rs2_data_ex, imm_ex, funct3_ex, alu_op_ex};
    endfunction

    task automatic check(input string name, input logic [191:0] act, input logic [191:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Drive one ID-side cycle, predict the result and hand it to the monitor
    task automatic cycle(input stim_t s);
        exp_t e;
        logic hazard;
        @(negedge clk);
        id_valid    = s.id.valid;
        {id_RegWrite, id_MemRead, id_MemWrite, id_MemtoReg, id_ALUSrc, id_Branch, id_Jump} = s.id.ctrl;
        id_rs1 = s.id.rs1; id_rs2 = s.id.rs2; id_rd = s.id.rd;
        id_pc = s.id.pc; id_rs1_data = s.id.d1; id_rs2_data = s.id.d2; id_imm = s.id.imm;
        id_funct3 = s.id.f3; id_alu_op = s.id.op;
        flush_ex = s.flush; mem_stall = s.mstall;

        // A load in EX whose non-zero destination is read by a live ID instruction
        hazard = s.id.valid && m_ex.valid && m_ex.ctrl[5] && (m_ex.rd != 0) &&
                 (m_ex.rd == s.id.rs1 || m_ex.rd == s.id.rs2);
        e.stall = s.mstall || (hazard && !s.flush);
        if (s.mstall) begin
            // frozen: nothing changes
        end else if (s.flush || hazard || !s.id.valid) begin
            m_ex = '0;
            if (!s.flush && hazard && m_cnt < CMAX) m_cnt = m_cnt + 1;
        end else begin
            m_ex = s.id;
        end
        e.ex  = m_ex;
        e.cnt = m_cnt;
        sb_q.push_back(e);
    endtask

    function automatic stim_t rand_stim();
        stim_t s;
        s.id.valid = ($urandom_range(0, 7) != 0);
        s.id.ctrl  = 7'($urandom);
        s.id.rd    = 5'($urandom_range(0, 3));
        s.id.rs1   = ($urandom_range(0, 2) == 0) ? m_ex.rd : 5'($urandom_range(0, 7));
        s.id.rs2   = ($urandom_range(0, 2) == 0) ? m_ex.rd : 5'($urandom_range(0, 7));
        s.id.pc    = $urandom;
        s.id.d1    = $urandom;
        s.id.d2    = $urandom;
        s.id.imm   = $urandom;
        s.id.f3    = 3'($urandom);
        s.id.op    = 4'($urandom);
        s.flush    = ($urandom_range(0, 7) == 0);
        s.mstall   = ($urandom_range(0, 5) == 0);
        return s;
    endfunction

    function automatic stim_t mk(input logic v, input logic memrd, input logic [4:0] rs1,
                                 input logic [4:0] rs2, input logic [4:0] rd,
                                 input logic fl, input logic ms);
        stim_t s;
        s = '0;
        s.id.valid   = v;
        s.id.ctrl    = 7'b1000000;
        s.id.ctrl[5] = memrd;
        s.id.rs1 = rs1; s.id.rs2 = rs2; s.id.rd = rd;
        s.id.pc  = 32'h1000 + 32'(rd);
        s.id.d1  = 32'hA5A5_0000 | 32'(rs1);
        s.id.d2  = 32'h5A5A_0000 | 32'(rs2);
        s.id.imm = 32'h0000_0040;
        s.id.f3  = 3'd2;
        s.id.op  = 4'd3;
        s.flush  = fl;
        s.mstall = ms;
        return s;
    endfunction

    // Monitor: compare stall before the edge, EX contents after it
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("stall_if_id", 192'(stall_if_id), 192'(e.stall));
                @(posedge clk);
                #1;
                check("ex_regs", 192'(dut_ex()), 192'(e.ex));
                check("bubble_count", 192'(bubble_count), 192'(e.cnt));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        m_ex  = '0;
        m_cnt = 0;
        #2;
        check("reset_ex", 192'(dut_ex()), 192'(0));
        check("reset_cnt", 192'(bubble_count), 192'(0));
        check("reset_stall", 192'(stall_if_id), 192'(0));
        #5 rst_n = 1'b1;

        // Load-use on x5: stall, one bubble, then the dependent op advances
        cycle(mk(1, 1, 1, 2, 5, 0, 0));
        cycle(mk(1, 0, 5, 3, 7, 0, 0));
        cycle(mk(1, 0, 5, 3, 7, 0, 0));
        // Load to x0 never triggers a hazard
        cycle(mk(1, 1, 1, 2, 0, 0, 0));
        cycle(mk(1, 0, 1, 0, 8, 0, 0));
        // Hazard with simultaneous flush: bubble, but no count
        cycle(mk(1, 1, 1, 2, 6, 0, 0));
        cycle(mk(1, 0, 6, 6, 9, 1, 0));
        // Freeze for three cycles with hazard and flush pending
        cycle(mk(1, 1, 1, 2, 5, 0, 0));
        for (int i = 0; i < 3; i++) cycle(mk(1, 0, 5, 1, 4, 1, 1));
        cycle(mk(1, 0, 5, 1, 4, 1, 0));
        // Drive the counter past saturation
        for (int i = 0; i < CMAX + 3; i++) begin
            cycle(mk(1, 1, 1, 2, 5, 0, 0));
            cycle(mk(1, 0, 3, 5, 4, 0, 0));
        end
        // Randomized traffic
        for (int i = 0; i < 1500; i++) cycle(rand_stim());

        // Asynchronous reset mid-cycle with a valid instruction in EX
        cycle(mk(1, 1, 1, 2, 5, 0, 0));
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_reset_ex", 192'(dut_ex()), 192'(0));
        check("async_reset_cnt", 192'(bubble_count), 192'(0));
        check("reset_stall_no_mstall", 192'(stall_if_id), 192'(0));
        mem_stall = 1'b1;
        #1;
        check("reset_stall_mstall", 192'(stall_if_id), 192'(1));
        mem_stall = 1'b0; id_valid = 1'b0; flush_ex = 1'b0;
        m_ex  = '0;
        m_cnt = 0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 200; i++) cycle(rand_stim());

        @(negedge clk);
        @(negedge clk);
        #4;
        check("scoreboard_drained", 192'(sb_q.size()), 192'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
